sobel_stream_core: RTL and testbench

- Parametrised streaming Sobel engine for the image-source -> edge-filter -> display chain.
- Accepts raster-order RGB pixels, converts them to grey, and builds a 3x3 window from two line buffers.
- Computes |Gx|+|Gy| and emits one output pixel per input pixel in one of four output modes.
- Self-flushes at frame end and pulses a done strobe that the display stage consumes.

---
 rtl/sobel_stream_core.sv | 279 +++++++++++++++++++++++++++
 tb/tb_sobel_stream_core.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_core.sv
// sobel_stream_core: streaming 3x3 Sobel edge filter.
// Raster RGB pixels are converted to grey and pushed through two line
// buffers into a 3x3 window. |Gx|+|Gy| is emitted one output per input pixel
// in one of four modes. The core flushes itself at frame end and pulses
// sobel_done_o after the last output.
// Optional build macro: SOBEL_EDGE_COUNT_EN adds edge_count_o, the number of
// outputs of the last frame whose magnitude reached the latched threshold.
module sobel_stream_core #(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int PIX_W = 8
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             data_valid_i,
  input  logic [PIX_W-1:0] data_red_i,
  input  logic [PIX_W-1:0] data_green_i,
  input  logic [PIX_W-1:0] data_blue_i,
  input  logic [1:0]       mode_i,
  input  logic [PIX_W-1:0] thresh_i,
  output logic             sobel_valid_o,
  output logic [PIX_W-1:0] sobel_data_o,
  output logic             sobel_done_o,
  output logic             busy_o,
  output logic             err_o
`ifdef SOBEL_EDGE_COUNT_EN
  ,
  output logic [$clog2(IMG_W*IMG_H):0] edge_count_o
`endif
);

  localparam int AW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H + 2);
  localparam int CRW = $clog2(IMG_H);
  localparam int GW  = PIX_W + 3;
  localparam int MW  = PIX_W + 4;

  localparam logic [AW-1:0]  COL_LAST  = AW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [RW-1:0]  ROW_PAD   = RW'(IMG_H + 1);
  localparam logic [CRW-1:0] CROW_LAST = CRW'(IMG_H - 1);
  localparam logic [MW-1:0]  MAG_MAX   = MW'((1 << PIX_W) - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_FLUSH, S_DONE} state_t;
  typedef enum logic [1:0] {MODE_MAG, MODE_BIN, MODE_GREY, MODE_INV} mode_t;

  state_t state, state_nxt;
  mode_t  mode_q;
  logic [PIX_W-1:0] thresh_q;

  // Advance index of the pixel currently entering the window
  logic [RW-1:0]  in_row;
  logic [AW-1:0]  in_col;
  // Position of the window centre for the next emitted output
  logic [CRW-1:0] c_row;
  logic [AW-1:0]  c_col;

  logic adv, start, done_set, err_set, emit;

  logic [PIX_W+1:0] grey_sum;
  logic [PIX_W-1:0] grey, pix_in;

  logic [PIX_W-1:0] lb_a [IMG_W];  // previous line
  logic [PIX_W-1:0] lb_b [IMG_W];  // line before that
  logic [PIX_W-1:0] win  [3][3];   // win[row][col], row 2 / col 2 newest
  logic             win_vld, win_border;

  logic signed [GW-1:0] gx_c, gy_c, gx_q, gy_q;
  logic                 grad_vld, grad_border;
  logic [PIX_W-1:0]     centre_q;

  logic [GW-1:0]    abs_x, abs_y;
  logic [MW-1:0]    mag;
  logic [PIX_W-1:0] mag_px, out_c;

  function automatic logic signed [GW-1:0] ext(input logic [PIX_W-1:0] v);
    return signed'({3'b000, v});
  endfunction

  // Grey conversion; flush cycles feed zero padding instead
  assign grey_sum = {2'b00, data_red_i} + {1'b0, data_green_i, 1'b0} + {2'b00, data_blue_i};
  assign grey     = PIX_W'(grey_sum >> 2);
  assign pix_in   = (state == S_FLUSH) ? '0 : grey;

  // An advance whose index is at least W+1 completes a window that yields an output
  assign emit    = adv && ((in_row > RW'(1)) || (in_row == RW'(1) && in_col != '0));
  assign err_set = data_valid_i && (state == S_FLUSH || state == S_DONE);
  assign busy_o  = (state == S_FILL) || (state == S_RUN) || (state == S_FLUSH);

  // Next-state and advance decode
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
    state_nxt = state;
    adv       = 1'b0;
    start     = 1'b0;
    done_set  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (data_valid_i) begin
          adv       = 1'b1;
          start     = 1'b1;
          state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        if (data_valid_i) begin
          adv = 1'b1;
          if (in_row == RW'(1) && in_col == AW'(1)) state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (data_valid_i) begin
          adv = 1'b1;
          if (in_row == ROW_LAST && in_col == COL_LAST) state_nxt = S_FLUSH;
        end
      end
      S_FLUSH: begin
        adv = 1'b1;
        if (in_row == ROW_PAD && in_col == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        // The last output is on the port and nothing is left behind it
        if (!win_vld && !grad_vld && sobel_valid_o) begin
          done_set  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, frame configuration, sticky error, done strobe
  always_ff @(posedge sys_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (sys_rst_i) begin
      state        <= S_IDLE;
      mode_q       <= MODE_MAG;
      thresh_q     <= '0;
      err_o        <= 1'b0;
      sobel_done_o <= 1'b0;
    end else begin
      state        <= state_nxt;
      err_o        <= err_o | err_set;
      sobel_done_o <= done_set;
      if (start) begin
        mode_q   <= mode_t'(mode_i);
        thresh_q <= thresh_i;
      end
    end
  end

  // Line buffers: each advance reads the column, then shifts it up one line
  always_ff @(posedge sys_clk_i) begin
    // NOTE: no reset on the line buffers; stale data only reaches border outputs, whose magnitude is forced to zero.
    if (adv) begin
      lb_a[in_col] <= pix_in;
      lb_b[in_col] <= lb_a[in_col];
    end
  end

  // Window shift, advance/centre counters and window-stage valid
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
      end
      in_row     <= '0;
      in_col     <= '0;
      c_row      <= '0;
      c_col      <= '0;
      win_vld    <= 1'b0;
      win_border <= 1'b0;
    end else begin
      win_vld <= emit;
      if (adv) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb_b[in_col];
        win[1][2] <= lb_a[in_col];
        win[2][2] <= pix_in;
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= in_row + RW'(1);
        end else begin
          in_col <= in_col + AW'(1);
        end
      end
      if (emit) begin
        win_border <= (c_row == '0) || (c_row == CROW_LAST) || (c_col == '0) || (c_col == COL_LAST);
        if (c_col == COL_LAST) begin
          c_col <= '0;
          c_row <= c_row + CRW'(1);
        end else begin
          c_col <= c_col + AW'(1);
        end
      end
      if (state == S_DONE) begin
        in_row <= '0;
        in_col <= '0;
        c_row  <= '0;
        c_col  <= '0;
      end
    end
  end

  assign gx_c = (ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2]))
              - (ext(win[0][0]) + (ext(win[1][0]) <<< 1) + ext(win[2][0]));
  assign gy_c = (ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2]))
              - (ext(win[0][0]) + (ext(win[0][1]) <<< 1) + ext(win[0][2]));

  // Gradient stage
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      grad_vld    <= 1'b0;
      grad_border <= 1'b0;
      gx_q        <= '0;
      gy_q        <= '0;
      centre_q    <= '0;
    end else begin
      grad_vld <= win_vld;
      if (win_vld) begin
        grad_border <= win_border;
        gx_q        <= gx_c;
        gy_q        <= gy_c;
        centre_q    <= win[1][1];
      end
    end
  end

  assign abs_x  = gx_q[GW-1] ? GW'(-gx_q) : GW'(gx_q);
  assign abs_y  = gy_q[GW-1] ? GW'(-gy_q) : GW'(gy_q);
  assign mag    = {1'b0, abs_x} + {1'b0, abs_y};
  assign mag_px = grad_border ? '0 : ((mag > MAG_MAX) ? '1 : mag[PIX_W-1:0]);

  // Output mode selection
  always_comb begin
    out_c = mag_px;
    unique case (mode_q)
      MODE_MAG:  out_c = mag_px;
      MODE_BIN:  out_c = (mag_px >= thresh_q) ? '1 : '0;
      MODE_GREY: out_c = centre_q;
      MODE_INV:  out_c = ~mag_px;
    endcase
  end

  // Output register
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      sobel_valid_o <= 1'b0;
      sobel_data_o  <= '0;
    end else begin
      sobel_valid_o <= grad_vld;
      if (grad_vld) sobel_data_o <= out_c;
    end
  end

`ifdef SOBEL_EDGE_COUNT_EN
  localparam int ECW = $clog2(IMG_W*IMG_H) + 1;
  logic [ECW-1:0] edge_cnt;

  // Per-frame edge counter, published when the done strobe fires
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      edge_cnt     <= '0;
      edge_count_o <= '0;
    end else begin
      if (start) begin
        edge_cnt <= '0;
      end else if (grad_vld && (mag_px >= thresh_q)) begin
        edge_cnt <= edge_cnt + ECW'(1);
      end
      if (done_set) edge_count_o <= edge_cnt;
    end
  end
`endif

endmodule

// File: tb/tb_sobel_stream_core.sv
// Directed testbench for sobel_stream_core on an 8x6 image.
module tb_sobel_stream_core;

  localparam int W    = 8;
  localparam int H    = 6;
  localparam int P    = 8;
  localparam int NPIX = W * H;

  localparam int K_FLAT    = 0;
  localparam int K_STEP_FF = 1;
  localparam int K_STEP_10 = 2;
  localparam int K_COLOUR  = 3;

  localparam int E_ZERO = 0;
  localparam int E_EDGE = 1;
  localparam int E_GREY = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         data_valid_i = 1'b0;
  logic [P-1:0] data_red_i = '0, data_green_i = '0, data_blue_i = '0;
  logic [1:0]   mode_i = '0;
  logic [P-1:0] thresh_i = '0;
  logic         sobel_valid_o, sobel_done_o, busy_o, err_o;
  logic [P-1:0] sobel_data_o;
`ifdef SOBEL_EDGE_COUNT_EN
  logic [$clog2(W*H):0] edge_count_o;
`endif

  sobel_stream_core #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
    .sys_clk_i    (clk),
    .sys_rst_i    (rst),
    .data_valid_i (data_valid_i),
    .data_red_i   (data_red_i),
    .data_green_i (data_green_i),
    .data_blue_i  (data_blue_i),
    .mode_i       (mode_i),
    .thresh_i     (thresh_i),
    .sobel_valid_o(sobel_valid_o),
    .sobel_data_o (sobel_data_o),
    .sobel_done_o (sobel_done_o),
    .busy_o       (busy_o),
    .err_o        (err_o)
`ifdef SOBEL_EDGE_COUNT_EN
    ,
    .edge_count_o (edge_count_o)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Output monitor, sampled on the falling edge
  logic [P-1:0] out_q[$];
  int first_vld_cyc = 0, last_vld_cyc = 0, done_cyc = 0, done_cnt = 0;
  int t_in = 0;

  always @(negedge clk) begin
    if (sobel_valid_o) begin
      if (out_q.size() == 0) first_vld_cyc = cyc;
      out_q.push_back(sobel_data_o);
      last_vld_cyc = cyc;
    end
    if (sobel_done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [23:0] pix_rgb(input int kind, input int x);
    case (kind)
      K_FLAT:    return 24'h808080;
      K_STEP_FF: return (x >= 4) ? 24'hFFFFFF : 24'h000000;
      K_STEP_10: return (x >= 4) ? 24'h101010 : 24'h000000;
      default:   return 24'h306090;
    endcase
  endfunction

  // Hand-derived expectations: a vertical step between cols 3 and 4 lights
  // cols 3 and 4 on the interior rows 1..H-2 only.
  function automatic logic [P-1:0] exp_pix(input int ek, input int y, input int x);
    case (ek)
      E_EDGE:  return (y >= 1 && y <= H - 2 && (x == 3 || x == 4)) ? 8'hFF : 8'h00;
      E_GREY:  return 8'h60;
      default: return 8'h00;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    out_q.delete();
    done_cnt = 0;
  endtask

  task automatic drive_frame(input int kind, input logic [1:0] mode, input logic [P-1:0] thr,
                             input int max_gap, input int npix, input bit mid_change,
                             input bit flush_poke);
    logic [23:0] c;
    int gap;
    mode_i   = mode;
    thresh_i = thr;
    for (int i = 0; i < npix; i++) begin
      c = pix_rgb(kind, i % W);
      data_red_i   = c[23:16];
      data_green_i = c[15:8];
      data_blue_i  = c[7:0];
      data_valid_i = 1'b1;
      if (i == W + 1) t_in = cyc;
      tick();
      data_valid_i = 1'b0;
      if (i == 0 && mid_change) begin
        mode_i   = ~mode;
        thresh_i = ~thr;
      end
      if (max_gap > 0) begin
        gap = int'($urandom_range(max_gap, 0));
        repeat (gap) tick();
      end
    end
    if (flush_poke) begin
      data_red_i   = 8'hAA;
      data_green_i = 8'h55;
      data_blue_i  = 8'hAA;
      data_valid_i = 1'b1;
      tick();
      data_valid_i = 1'b0;
    end
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done_cnt == 0 && n < 200) begin
      tick();
      n++;
    end
    check({tag, " done within budget"}, 32'(done_cnt != 0), 32'd1);
    repeat (6) tick();
  endtask

  task automatic check_frame(input string tag, input int ek);
    logic [P-1:0] obs;
    check({tag, " output count"}, 32'(out_q.size()), 32'(NPIX));
    for (int i = 0; i < NPIX; i++) begin
      obs = (i < out_q.size()) ? out_q[i] : 'x;
      check($sformatf("%s y%0d x%0d", tag, i / W, i % W), 32'(obs), 32'(exp_pix(ek, i / W, i % W)));
    end
    check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
    check({tag, " done one cycle after last output"}, 32'(done_cyc - last_vld_cyc), 32'd1);
    check({tag, " busy low after"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset valid", 32'(sobel_valid_o), 32'd0);
    check("reset data", 32'(sobel_data_o), 32'd0);
    check("reset done", 32'(sobel_done_o), 32'd0);
    check("reset busy", 32'(busy_o), 32'd0);
    check("reset err", 32'(err_o), 32'd0);
`ifdef SOBEL_EDGE_COUNT_EN
    check("reset edge count", 32'(edge_count_o), 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Flat grey: no gradient anywhere
    clear_mon();
    drive_frame(K_FLAT, 2'b00, 8'h00, 0, NPIX, 1'b0, 1'b0);
    check("flat busy in flush", 32'(busy_o), 32'd1);
    wait_done("flat");
    check("flat latency", 32'(first_vld_cyc - t_in), 32'd3);
    check_frame("flat", E_ZERO);

    // Saturating step, magnitude mode
    clear_mon();
    drive_frame(K_STEP_FF, 2'b00, 8'h00, 0, NPIX, 1'b0, 1'b0);
    wait_done("step_ff");
    check_frame("step_ff", E_EDGE);

    // Small step, binary mode, threshold exactly at the magnitude
    clear_mon();
    drive_frame(K_STEP_10, 2'b01, 8'h40, 0, NPIX, 1'b0, 1'b0);
    wait_done("bin40");
    check_frame("bin40", E_EDGE);
`ifdef SOBEL_EDGE_COUNT_EN
    check("bin40 edge count", 32'(edge_count_o), 32'd8);
`endif

    // Threshold one above the magnitude
    clear_mon();
    drive_frame(K_STEP_10, 2'b01, 8'h41, 0, NPIX, 1'b0, 1'b0);
    wait_done("bin41");
    check_frame("bin41", E_ZERO);
`ifdef SOBEL_EDGE_COUNT_EN
    check("bin41 edge count", 32'(edge_count_o), 32'd0);
`endif

    // Grey pass-through including border
    clear_mon();
    drive_frame(K_COLOUR, 2'b10, 8'h00, 0, NPIX, 1'b0, 1'b0);
    wait_done("grey");
    check_frame("grey", E_GREY);

    // Random input gaps, mode/threshold changed after the first pixel
    clear_mon();
    drive_frame(K_STEP_FF, 2'b00, 8'h00, 3, NPIX, 1'b1, 1'b0);
    wait_done("gaps");
    check_frame("gaps", E_EDGE);

    // Reset after pixel 20 aborts the frame
    clear_mon();
    drive_frame(K_STEP_FF, 2'b00, 8'h00, 3, 20, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    check("abort valid", 32'(sobel_valid_o), 32'd0);
    check("abort busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    clear_mon();
    repeat (30) tick();
    check("abort no outputs", 32'(out_q.size()), 32'd0);
    check("abort no done", 32'(done_cnt), 32'd0);

    // A full frame after the abort is clean
    clear_mon();
    drive_frame(K_STEP_FF, 2'b00, 8'h00, 0, NPIX, 1'b0, 1'b0);
    wait_done("post_abort");
    check_frame("post_abort", E_EDGE);
    check("err clear before poke", 32'(err_o), 32'd0);

    // Input during flush flags an error but leaves the frame intact
    clear_mon();
    drive_frame(K_STEP_10, 2'b01, 8'h40, 0, NPIX, 1'b0, 1'b1);
    check("err set by flush input", 32'(err_o), 32'd1);
    wait_done("poke");
    check_frame("poke", E_EDGE);
`ifdef SOBEL_EDGE_COUNT_EN
    check("poke edge count", 32'(edge_count_o), 32'd8);
`endif
    repeat (20) tick();
    check("err sticky", 32'(err_o), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
